// File: rtl/line_buffer_ctrl.sv
// Ping-pong line RAM scheduler: fills one bank from the capture path while vga_control streams the other.
// Optional macro LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN reads every stored pixel twice (2x horizontal scaling).
module line_buffer_ctrl #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8
) (
  input  logic              VIDEO_CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              IN_FRAME_START,
  input  logic              IN_LINE_START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              OUT_LINE_START,
  input  logic              OUT_VISIBLE,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              RAM_WE,
  output logic [ADDR_W:0]   RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_RE,
  output logic [ADDR_W:0]   RAM_RADDR,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  output logic              OVERRUN,
  output logic              WR_BANK
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DONE} wstate_t;
  typedef enum logic {R_IDLE, R_ACTIVE} rstate_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_WIDTH - 1);

  wstate_t             wstate_reg, wstate_next;
  rstate_t             rstate_reg, rstate_next;
  logic [ADDR_W-1:0]   waddr_reg, waddr_next;
  logic [ADDR_W-1:0]   raddr_reg, raddr_next;
  logic                wr_bank_reg, wr_bank_next;
  logic                rd_bank_reg, rd_bank_next;
  logic                line_full_reg, line_full_next;
  logic                overrun_reg, overrun_next;
  logic                out_valid_reg;
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
  logic                phase_reg, phase_next;
`endif

  logic write_en;
  logic read_en;
  logic swap;

  // A pixel arriving together with a line/frame start belongs to no line and is dropped.
  assign write_en = ENABLE && (wstate_reg == W_FILL) && IN_VALID && !IN_LINE_START && !IN_FRAME_START;
  assign read_en  = ENABLE && (rstate_reg == R_ACTIVE) && OUT_VISIBLE && !OUT_LINE_START;
  assign swap     = ENABLE && OUT_LINE_START && line_full_reg;

  assign RAM_WE    = write_en;
  assign RAM_WADDR = write_en ? {wr_bank_reg, waddr_reg} : '0;
  assign RAM_WDATA = write_en ? IN_DATA : '0;
  assign RAM_RE    = read_en;
  assign RAM_RADDR = read_en ? {rd_bank_reg, raddr_reg} : '0;
  assign OUT_VALID = out_valid_reg;
  assign OUT_DATA  = out_valid_reg ? RAM_RDATA : '0;
  assign OVERRUN   = overrun_reg;
  assign WR_BANK   = wr_bank_reg;

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      wstate_reg    <= W_IDLE;
      rstate_reg    <= R_IDLE;
      waddr_reg     <= '0;
      raddr_reg     <= '0;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b1;
      line_full_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
      phase_reg     <= 1'b0;
`endif
    end else begin
      wstate_reg    <= wstate_next;
      rstate_reg    <= rstate_next;
      waddr_reg     <= waddr_next;
      raddr_reg     <= raddr_next;
      wr_bank_reg   <= wr_bank_next;
      rd_bank_reg   <= rd_bank_next;
      line_full_reg <= line_full_next;
      overrun_reg   <= overrun_next;
      out_valid_reg <= read_en;
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
      phase_reg     <= phase_next;
`endif
    end
  end

  // Writer and bank ownership; the swap decision uses the registered line_full only.
  always_comb begin
    wstate_next    = wstate_reg;
    waddr_next     = waddr_reg;
    wr_bank_next   = wr_bank_reg;
    rd_bank_next   = rd_bank_reg;
    line_full_next = line_full_reg;
    overrun_next   = overrun_reg;
    if (ENABLE) begin
      if (swap) begin
        wr_bank_next   = ~wr_bank_reg;
        rd_bank_next   = wr_bank_reg;
        line_full_next = 1'b0;
        waddr_next     = '0;
        wstate_next    = IN_LINE_START ? W_FILL : W_IDLE;
      end else if (IN_FRAME_START) begin
        line_full_next = 1'b0;
        waddr_next     = '0;
        wstate_next    = IN_LINE_START ? W_FILL : W_IDLE;
      end else begin
        case (wstate_reg)
          W_IDLE: begin
            if (IN_LINE_START) begin
              wstate_next = W_FILL;
              waddr_next  = '0;
            end
          end
          W_FILL: begin
            if (IN_LINE_START) begin
              waddr_next = '0;
            end else if (write_en) begin
              if (waddr_reg == LAST_ADDR) begin
                wstate_next    = W_DONE;
                waddr_next     = '0;
                line_full_next = 1'b1;
              end else begin
                waddr_next = waddr_reg + ADDR_W'(1);
              end
            end
          end
          W_DONE: begin
            if (IN_LINE_START) begin
              overrun_next   = 1'b1;
              line_full_next = 1'b0;
              waddr_next     = '0;
              wstate_next    = W_FILL;
            end
          end
          default: wstate_next = W_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rstate_next = rstate_reg;
    raddr_next  = raddr_reg;
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
    phase_next  = phase_reg;
`endif
    if (ENABLE) begin
      if (OUT_LINE_START) begin
        rstate_next = R_ACTIVE;
        raddr_next  = '0;
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
        phase_next  = 1'b0;
`endif
      end else if (read_en) begin
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
        phase_next = ~phase_reg;
        if (phase_reg) begin
          if (raddr_reg == LAST_ADDR) begin
            rstate_next = R_IDLE;
            raddr_next  = '0;
          end else begin
            raddr_next = raddr_reg + ADDR_W'(1);
          end
        end
`else
        if (raddr_reg == LAST_ADDR) begin
          rstate_next = R_IDLE;
          raddr_next  = '0;
        end else begin
          raddr_next = raddr_reg + ADDR_W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: random pixel lines, a RAM model, and a line-level model of bank ownership.
module tb_line_buffer_ctrl;
  localparam int LW = 512;
  localparam int AW = 9;
  localparam int DW = 8;
`ifdef LINE_BUFFER_CTRL_PIXEL_DOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RESET = 1'b1, ENABLE = 1'b1, IN_FRAME_START = 1'b0, IN_LINE_START = 1'b0;
  logic          IN_VALID = 1'b0, OUT_LINE_START = 1'b0, OUT_VISIBLE = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic [DW-1:0] RAM_RDATA, RAM_WDATA, OUT_DATA;
  logic          RAM_WE, RAM_RE, OUT_VALID, OVERRUN, WR_BANK;
  logic [AW:0]   RAM_WADDR, RAM_RADDR;

  line_buffer_ctrl #(.LINE_WIDTH(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .VIDEO_CLK(clk), .RESET(RESET), .ENABLE(ENABLE), .IN_FRAME_START(IN_FRAME_START),
    .IN_LINE_START(IN_LINE_START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .OUT_LINE_START(OUT_LINE_START), .OUT_VISIBLE(OUT_VISIBLE), .RAM_RDATA(RAM_RDATA),
    .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_RE(RAM_RE),
    .RAM_RADDR(RAM_RADDR), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OVERRUN(OVERRUN),
    .WR_BANK(WR_BANK)
  );

  // Two-bank RAM with registered read, cleared on reset.
  logic [DW-1:0] mem [0:2*LW-1];
  logic [DW-1:0] rdata;
  assign RAM_RDATA = rdata;
  always @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 2*LW; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (RAM_WE) mem[RAM_WADDR] <= RAM_WDATA;
      if (RAM_RE) rdata <= mem[RAM_RADDR];
    end
  end

  // Monitor samples on the falling edge.
  logic [AW:0]   wa_q[$], ra_q[$];
  logic [DW-1:0] wd_q[$], od_q[$];
  int idle_bad = 0, inv_bad = 0;
  always @(negedge clk) begin
    if (RAM_WE) begin
      wa_q.push_back(RAM_WADDR);
      wd_q.push_back(RAM_WDATA);
    end
    if (RAM_RE) ra_q.push_back(RAM_RADDR);
    if (OUT_VALID) od_q.push_back(OUT_DATA);
    else if (OUT_DATA !== '0) idle_bad <= idle_bad + 1;
    if (RAM_WE && RAM_RE && (RAM_WADDR[AW] == RAM_RADDR[AW])) inv_bad <= inv_bad + 1;
  end

  // Line-level model: which bank holds what, and who owns which bank.
  logic [DW-1:0] content [2][LW];
  logic [DW-1:0] cur [LW];
  bit exp_wr, exp_rd, exp_full, exp_ovr;
  int checks = 0, errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); ra_q.delete(); od_q.delete();
  endtask

  task automatic model_reset();
    exp_wr = 0; exp_rd = 1; exp_full = 0; exp_ovr = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LW; i++) content[b][i] = '0;
  endtask

  task automatic model_out_line();
    if (exp_full) begin
      exp_rd = exp_wr;
      exp_wr = ~exp_wr;
      exp_full = 0;
    end
  endtask

  task automatic fill_line(input bit ramp);
    for (int i = 0; i < LW; i++) cur[i] = ramp ? DW'(i % 256) : DW'($urandom_range(0, 255));
  endtask

  // Sends n pixels of cur after a line start; optionally pulses OUT_LINE_START with the last pixel.
  task automatic send_line(input string tag, input int n, input bit ols_last);
    int i, bad;
    bit bank;
    if (exp_full) begin
      exp_ovr = 1;
      exp_full = 0;
    end
    bank = exp_wr;
    clear_mon();
    IN_LINE_START = 1; step(); IN_LINE_START = 0;
    i = 0;
    while (i < n) begin
      if ($urandom_range(0, 3) == 0) IN_VALID = 0;
      else begin
        IN_VALID = 1;
        IN_DATA = cur[i];
        if (ols_last && i == n - 1) OUT_LINE_START = 1;
        i++;
      end
      step();
      OUT_LINE_START = 0;
    end
    IN_VALID = 0;
    step();
    if (ols_last) model_out_line();
    for (int k = 0; k < n; k++) content[bank][k] = cur[k];
    if (n == LW) exp_full = 1;
    chk({tag, "_wr_count"}, wa_q.size(), n);
    bad = 0;
    for (int k = 0; k < wa_q.size() && k < n; k++)
      if (wa_q[k] !== {bank, AW'(k)} || wd_q[k] !== cur[k]) bad++;
    chk({tag, "_wr_content"}, bad, 0);
  endtask

  task automatic read_run(input string tag, input bit pulse, input bit rnd);
    int bad_a, bad_d;
    logic [AW:0] ea;
    clear_mon();
    if (pulse) begin
      model_out_line();
      OUT_LINE_START = 1; step(); OUT_LINE_START = 0;
    end
    for (int c = 0; c < 2*REP*LW; c++) begin
      OUT_VISIBLE = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      step();
    end
    OUT_VISIBLE = 0;
    repeat (3) step();
    chk({tag, "_re_count"}, ra_q.size(), REP*LW);
    chk({tag, "_valid_count"}, od_q.size(), REP*LW);
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < ra_q.size() && i < REP*LW; i++) begin
      ea = {exp_rd, AW'(i / REP)};
      if (ra_q[i] !== ea) bad_a++;
    end
    for (int i = 0; i < od_q.size() && i < REP*LW; i++)
      if (od_q[i] !== content[exp_rd][i / REP]) bad_d++;
    chk({tag, "_raddr"}, bad_a, 0);
    chk({tag, "_data"}, bad_d, 0);
    chk({tag, "_wr_bank"}, WR_BANK, exp_wr);
    chk({tag, "_overrun"}, OVERRUN, exp_ovr);
    chk({tag, "_valid_low"}, OUT_VALID, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk("rst_we", RAM_WE, 0);
    chk("rst_re", RAM_RE, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_wr_bank", WR_BANK, 0);
    RESET = 0;
    step();

    // Read before any line arrives: bank 1 replayed, no swap.
    read_run("empty_read", 1, 1);

    // Ramp line into bank 0, then read it out with swap.
    fill_line(1);
    send_line("ramp_fill", LW, 0);
    chk("ramp_overrun", OVERRUN, 0);
    read_run("ramp_read", 1, 0);
    read_run("ramp_replay", 1, 1);

    // Two lines without an intervening output line start -> overrun.
    fill_line(0);
    send_line("lineb_fill", LW, 0);
    chk("lineb_overrun", OVERRUN, 0);
    fill_line(0);
    send_line("linec_fill", LW, 0);
    chk("linec_overrun", OVERRUN, 1);
    read_run("linec_read", 1, 1);

    // Last pixel coincides with OUT_LINE_START: no swap until the next pulse.
    fill_line(0);
    send_line("lined_fill", LW, 1);
    read_run("lined_noswap", 0, 1);
    read_run("lined_read", 1, 1);

    // Frame start mid-fill, stray pixels while idle, then a full line from address 0.
    fill_line(0);
    send_line("linee_part", 200, 0);
    IN_FRAME_START = 1; step(); IN_FRAME_START = 0;
    exp_full = 0;
    clear_mon();
    IN_VALID = 1;
    repeat (8) step();
    IN_VALID = 0;
    step();
    chk("frame_idle_writes", wa_q.size(), 0);
    fill_line(0);
    send_line("linef_fill", LW, 0);
    read_run("linef_read", 1, 1);

    // ENABLE low: pulses and strobes are ignored, writer stays idle.
    clear_mon();
    ENABLE = 0;
    IN_LINE_START = 1; step(); IN_LINE_START = 0;
    IN_VALID = 1;
    repeat (10) step();
    ENABLE = 1;
    repeat (5) step();
    IN_VALID = 0;
    step();
    chk("disable_writes", wa_q.size(), 0);

    // Reset mid-line clears overrun and bank ownership.
    fill_line(0);
    send_line("lineg_part", 50, 0);
    RESET = 1; step(); RESET = 0;
    model_reset();
    step();
    chk("midrst_overrun", OVERRUN, 0);
    chk("midrst_wr_bank", WR_BANK, 0);
    fill_line(0);
    send_line("lineh_fill", LW, 0);
    read_run("lineh_read", 1, 1);

    chk("out_data_zero_when_invalid", idle_bad, 0);
    chk("no_read_of_write_bank", inv_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
